// File: rtl/wishbone_to_ahb_if.sv
// Signal bundle for the bridge: Wishbone classic slave side plus AHB-Lite master side.
// The slave modport is the bridge's view; master is the view of whatever sits around it.
interface wishbone_to_ahb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [3:0]            wb_sel;
    logic [DATA_WIDTH-1:0] wb_dat_w;
    logic [DATA_WIDTH-1:0] wb_dat_r;
    logic                  wb_ack;
    logic                  wb_err;

    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w, HRDATA, HREADY, HRESP,
        output wb_dat_r, wb_ack, wb_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_w, HRDATA, HREADY, HRESP,
        input  wb_dat_r, wb_ack, wb_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge: each Wishbone cycle becomes one
// SINGLE AHB transfer, strictly one at a time.
module wishbone_to_ahb #(
    parameter logic [3:0] HPROT_VALUE = 4'b0011,
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    wishbone_to_ahb_if.slave       bus
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e                state_q;
    logic [1:0]            htrans_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  abort_q;

    logic                  sel_ok_d;
    logic [2:0]            sel_size_d;
    logic [1:0]            sel_lo_d;
    logic                  aborting;
    logic                  unused_adr_bits;

    assign unused_adr_bits = &{1'b0, bus.wb_adr[1:0], 1'b0};

    // Only naturally aligned byte, halfword and word lane patterns map onto an AHB transfer.
    always_comb begin
        sel_ok_d   = 1'b1;
        sel_size_d = 3'b010;
        sel_lo_d   = 2'b00;
        case (bus.wb_sel)
            4'b0001: begin sel_size_d = 3'b000; sel_lo_d = 2'b00; end
            4'b0010: begin sel_size_d = 3'b000; sel_lo_d = 2'b01; end
            4'b0100: begin sel_size_d = 3'b000; sel_lo_d = 2'b10; end
            4'b1000: begin sel_size_d = 3'b000; sel_lo_d = 2'b11; end
            4'b0011: begin sel_size_d = 3'b001; sel_lo_d = 2'b00; end
            4'b1100: begin sel_size_d = 3'b001; sel_lo_d = 2'b10; end
            4'b1111: begin sel_size_d = 3'b010; sel_lo_d = 2'b00; end
            default: sel_ok_d = 1'b0;
        endcase
    end

    // A master that drops wb_cyc on the completing edge must not see a late termination.
    assign aborting = abort_q || !bus.wb_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            htrans_q <= TRANS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b010;
            hwdata_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wb_cyc && bus.wb_stb) begin
                        hwrite_q <= bus.wb_we;
                        hwdata_q <= bus.wb_dat_w;
                        haddr_q  <= {bus.wb_adr[ADDR_WIDTH-1:2], sel_lo_d};
                        hsize_q  <= sel_size_d;
                        if (sel_ok_d) begin
                            htrans_q <= TRANS_NONSEQ;
                            state_q  <= ADDR;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (!bus.wb_cyc) abort_q <= 1'b1;
                    if (bus.HREADY) begin
                        htrans_q <= TRANS_IDLE;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (!bus.wb_cyc) abort_q <= 1'b1;
                    // An ERROR response's first, not-ready cycle is deliberately ignored here.
                    if (bus.HREADY) begin
                        if (!hwrite_q) rdata_q <= bus.HRDATA;
                        ack_q   <= !aborting && !bus.HRESP;
                        err_q   <= !aborting && bus.HRESP;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    abort_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VALUE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = hwdata_q;
    assign bus.wb_dat_r  = rdata_q;
    assign bus.wb_ack    = ack_q;
    assign bus.wb_err    = err_q;
endmodule

// File: tb/tb_wishbone_to_ahb.sv
// Bench for wishbone_to_ahb: a Wishbone master driver, a behavioural AHB-Lite slave
// and a queue of expected terminations compared as each transfer ends.
module tb_wishbone_to_ahb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wishbone_to_ahb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wishbone_to_ahb #(.HPROT_VALUE(4'b0011), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          ack;
        bit          err;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastRead = 32'h0;

    int          cfgWait = 0;
    int          cfgAddrWait = 0;
    bit          cfgErr = 1'b0;
    logic [31:0] cfgRdata = 32'h0;
    int          dataDone = 0;
    int          nonseqCycles = 0;
    int          ahbViol = 0;
    logic [31:0] capAddr = 32'h0;
    logic [31:0] capWdata = 32'h0;
    logic [2:0]  capSize = 3'b0;
    logic        capWrite = 1'b0;

    // Behavioural AHB-Lite slave; also watches the master-side protocol rules.
    initial begin : ahbSlave
        bit          dataActive = 1'b0;
        bit          errFirst = 1'b0;
        bit          rstAtEdge;
        int          waitLeft = 0;
        int          addrWaitLeft = 0;
        logic [1:0]  pTrans = 2'b00;
        logic        pReady = 1'b1;
        logic [31:0] pAddr = 32'h0;
        logic [31:0] pWdata = 32'h0;
        logic [2:0]  pSize = 3'b0;
        logic        pWrite = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            @(posedge clk);
            rstAtEdge = rst;
            #1;
            if (rstAtEdge) begin
                dataActive   = 1'b0;
                addrWaitLeft = 0;
            end else begin
                if (pTrans == 2'b10) nonseqCycles++;
                if (pTrans == 2'b10 && !pReady && (bus.HTRANS !== pTrans || bus.HADDR !== pAddr ||
                    bus.HSIZE !== pSize || bus.HWRITE !== pWrite)) ahbViol++;
                if (pTrans == 2'b10 && pReady && bus.HTRANS == 2'b10) ahbViol++;
                if (dataActive && pReady) begin
                    dataActive = 1'b0;
                    capWdata   = pWdata;
                    dataDone++;
                end
                if (pTrans == 2'b10 && pReady) begin
                    dataActive = 1'b1;
                    waitLeft   = cfgWait;
                    errFirst   = cfgErr;
                    capAddr    = pAddr;
                    capSize    = pSize;
                    capWrite   = pWrite;
                end
                if (bus.HTRANS == 2'b10 && pTrans != 2'b10) addrWaitLeft = cfgAddrWait;
            end
            if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) ahbViol++;
            if (bus.HTRANS !== 2'b00 && bus.HTRANS !== 2'b10) ahbViol++;
            if (bus.wb_ack === 1'b1 && bus.wb_err === 1'b1) ahbViol++;
            if (dataActive) begin
                if (cfgErr) begin
                    bus.HRESP  = 1'b1;
                    bus.HREADY = !errFirst;
                    bus.HRDATA = 32'hE0E0_E0E0;
                    errFirst   = 1'b0;
                end else if (waitLeft > 0) begin
                    bus.HRESP  = 1'b0;
                    bus.HREADY = 1'b0;
                    bus.HRDATA = 32'hBAD0_BAD0;
                    waitLeft--;
                end else begin
                    bus.HRESP  = 1'b0;
                    bus.HREADY = 1'b1;
                    bus.HRDATA = cfgRdata;
                end
            end else if (addrWaitLeft > 0 && bus.HTRANS == 2'b10) begin
                bus.HRESP  = 1'b0;
                bus.HREADY = 1'b0;
                addrWaitLeft--;
            end else begin
                bus.HRESP  = 1'b0;
                bus.HREADY = 1'b1;
                bus.HRDATA = 32'h0;
            end
            pTrans = bus.HTRANS;
            pReady = bus.HREADY;
            pAddr  = bus.HADDR;
            pSize  = bus.HSIZE;
            pWrite = bus.HWRITE;
            pWdata = bus.HWDATA;
        end
    end

    // Runs one Wishbone cycle and reports how and when it terminated (cycles=-1 on timeout).
    task automatic wbTransfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat, output logic gotAck, output logic gotErr,
                              output logic [31:0] gotDat, output int cycles, output logic linger);
        @(posedge clk); #1;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_adr = adr; bus.wb_sel = sel; bus.wb_dat_w = dat;
        @(posedge clk);
        cycles = -1; gotAck = 1'b0; gotErr = 1'b0; gotDat = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.wb_ack === 1'b1 || bus.wb_err === 1'b1) begin
                cycles = i; gotAck = bus.wb_ack; gotErr = bus.wb_err; gotDat = bus.wb_dat_r;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        @(negedge clk);
        linger = bus.wb_ack || bus.wb_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = 32'h0; bus.wb_sel = 4'h0; bus.wb_dat_w = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.HTRANS !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_htrans: got %b expected 00", bus.HTRANS);
        end
        checks++;
        if ({bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA} !== {32'h0, 1'b0, 3'b010, 32'h0}) begin
            errors++; $display("[TB] FAIL reset_ctrl: got addr=%h wr=%b size=%b wdata=%h expected 0/0/010/0",
                               bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA);
        end
        checks++;
        if ({bus.wb_dat_r, bus.wb_ack, bus.wb_err} !== {32'h0, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL reset_wb: got dat=%h ack=%b err=%b expected 0/0/0",
                               bus.wb_dat_r, bus.wb_ack, bus.wb_err);
        end
        checks++;
        if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
            errors++; $display("[TB] FAIL reset_const: got burst=%b prot=%b lock=%b expected 000/0011/0",
                               bus.HBURST, bus.HPROT, bus.HMASTLOCK);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.wb_ack !== 1'b0 || bus.wb_err !== 1'b0 || bus.HTRANS !== 2'b00) begin
            errors++; $display("[TB] FAIL idle_quiet: got ack=%b err=%b htrans=%b expected 0/0/00",
                               bus.wb_ack, bus.wb_err, bus.HTRANS);
        end
    endtask

    task automatic test_word_read();
        logic a, er, lg; logic [31:0] d; int cyc, ns0; exp_t e;
        cfgRdata = 32'hDEAD_BEEF; ns0 = nonseqCycles;
        lastRead = 32'hDEAD_BEEF;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: 32'hDEAD_BEEF, lat: 3});
        wbTransfer(1'b0, 32'h0000_1004, 4'b1111, 32'h0, a, er, d, cyc, lg);
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || lg !== 1'b0) begin
            errors++; $display("[TB] FAIL word_read_resp: got ack=%b err=%b lat=%0d linger=%b expected %b/%b/%0d/0",
                               a, er, cyc, lg, e.ack, e.err, e.lat);
        end
        checks++;
        if (d !== e.dat) begin
            errors++; $display("[TB] FAIL word_read_data: got %h expected %h", d, e.dat);
        end
        checks++;
        if (capAddr !== 32'h1004 || capSize !== 3'b010 || capWrite !== 1'b0 || nonseqCycles - ns0 != 1) begin
            errors++; $display("[TB] FAIL word_read_ahb: got addr=%h size=%b wr=%b nonseq=%0d expected 1004/010/0/1",
                               capAddr, capSize, capWrite, nonseqCycles - ns0);
        end
    endtask

    task automatic test_byte_write();
        logic a, er, lg; logic [31:0] d; int cyc; exp_t e;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: lastRead, lat: 3});
        wbTransfer(1'b1, 32'h0000_2000, 4'b0100, 32'h00AB_0000, a, er, d, cyc, lg);
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || lg !== 1'b0) begin
            errors++; $display("[TB] FAIL byte_write_resp: got ack=%b err=%b lat=%0d linger=%b expected %b/%b/%0d/0",
                               a, er, cyc, lg, e.ack, e.err, e.lat);
        end
        checks++;
        if (capAddr !== 32'h2002 || capSize !== 3'b000 || capWrite !== 1'b1 || capWdata !== 32'h00AB_0000) begin
            errors++; $display("[TB] FAIL byte_write_ahb: got addr=%h size=%b wr=%b wdata=%h expected 2002/000/1/00ab0000",
                               capAddr, capSize, capWrite, capWdata);
        end
        checks++;
        if (d !== e.dat) begin
            errors++; $display("[TB] FAIL byte_write_rdata_held: got %h expected %h", d, e.dat);
        end
    endtask

    task automatic test_half_read_wait();
        logic a, er, lg; logic [31:0] d; int cyc; exp_t e;
        cfgRdata = 32'h1234_5678; cfgWait = 3;
        lastRead = 32'h1234_5678;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: 32'h1234_5678, lat: 6});
        wbTransfer(1'b0, 32'h0000_3000, 4'b1100, 32'h0, a, er, d, cyc, lg);
        cfgWait = 0;
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || d !== e.dat) begin
            errors++; $display("[TB] FAIL half_read_wait: got ack=%b err=%b lat=%0d dat=%h expected %b/%b/%0d/%h",
                               a, er, cyc, d, e.ack, e.err, e.lat, e.dat);
        end
        checks++;
        if (capAddr !== 32'h3002 || capSize !== 3'b001) begin
            errors++; $display("[TB] FAIL half_read_ahb: got addr=%h size=%b expected 3002/001", capAddr, capSize);
        end
    endtask

    task automatic test_error();
        logic a, er, lg; logic [31:0] d; int cyc; exp_t e;
        cfgErr = 1'b1;
        expQ.push_back('{ack: 1'b0, err: 1'b1, dat: lastRead, lat: 4});
        wbTransfer(1'b1, 32'h0000_7000, 4'b1111, 32'h1111_2222, a, er, d, cyc, lg);
        cfgErr = 1'b0;
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || lg !== 1'b0 || d !== e.dat) begin
            errors++; $display("[TB] FAIL error_resp: got ack=%b err=%b lat=%0d linger=%b dat=%h expected %b/%b/%0d/0/%h",
                               a, er, cyc, lg, d, e.ack, e.err, e.lat, e.dat);
        end
    endtask

    task automatic test_invalid_sel();
        logic a, er, lg; logic [31:0] d; int cyc, ns0; exp_t e;
        logic [3:0] badSel [4] = '{4'b0101, 4'b0000, 4'b0110, 4'b1110};
        for (int i = 0; i < 4; i++) begin
            ns0 = nonseqCycles;
            expQ.push_back('{ack: 1'b0, err: 1'b1, dat: lastRead, lat: 1});
            wbTransfer(1'b0, 32'h0000_9000, badSel[i], 32'h0, a, er, d, cyc, lg);
            e = expQ.pop_front();
            checks++;
            if ({a, er} !== {e.ack, e.err} || cyc != e.lat || lg !== 1'b0 || nonseqCycles != ns0) begin
                errors++; $display("[TB] FAIL invalid_sel_%b: got ack=%b err=%b lat=%0d linger=%b nonseq=%0d expected %b/%b/%0d/0/0",
                                   badSel[i], a, er, cyc, lg, nonseqCycles - ns0, e.ack, e.err, e.lat);
            end
        end
    endtask

    task automatic test_sel_decode();
        logic a, er, lg; logic [31:0] d, adr, rd; int cyc; exp_t e;
        logic [3:0] sel [4]  = '{4'b0001, 4'b0010, 4'b1000, 4'b0011};
        logic [1:0] lo [4]   = '{2'b00, 2'b01, 2'b11, 2'b00};
        logic [2:0] size [4] = '{3'b000, 3'b000, 3'b000, 3'b001};
        for (int i = 0; i < 4; i++) begin
            adr = 32'h0000_8003 + 32'(i * 16);
            rd = 32'hA500_0000 + 32'(i);
            cfgRdata = rd; lastRead = rd;
            expQ.push_back('{ack: 1'b1, err: 1'b0, dat: rd, lat: 3});
            wbTransfer(1'b0, adr, sel[i], 32'h0, a, er, d, cyc, lg);
            e = expQ.pop_front();
            checks++;
            if ({a, er} !== {e.ack, e.err} || cyc != e.lat || d !== e.dat ||
                capAddr !== {adr[31:2], lo[i]} || capSize !== size[i]) begin
                errors++; $display("[TB] FAIL sel_decode_%b: got ack=%b lat=%0d dat=%h addr=%h size=%b expected 1/%0d/%h/%h/%b",
                                   sel[i], a, cyc, d, capAddr, capSize, e.lat, e.dat, {adr[31:2], lo[i]}, size[i]);
            end
        end
    endtask

    task automatic test_addr_wait();
        logic a, er, lg; logic [31:0] d; int cyc; exp_t e;
        cfgAddrWait = 2;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: lastRead, lat: 5});
        wbTransfer(1'b1, 32'h0000_A000, 4'b0011, 32'h0000_BEEF, a, er, d, cyc, lg);
        cfgAddrWait = 0;
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || capWdata !== 32'h0000_BEEF || capSize !== 3'b001) begin
            errors++; $display("[TB] FAIL addr_wait: got ack=%b err=%b lat=%0d wdata=%h size=%b expected %b/%b/%0d/0000beef/001",
                               a, er, cyc, capWdata, capSize, e.ack, e.err, e.lat);
        end
        checks++;
        if (ahbViol != 0) begin
            errors++; $display("[TB] FAIL ahb_rules: got %0d violations expected 0", ahbViol);
        end
    endtask

    task automatic test_abort();
        logic a, er, lg; logic [31:0] d; int cyc, done0; exp_t e;
        bit sawAck = 1'b0, sawErr = 1'b0;
        cfgWait = 2; done0 = dataDone;
        expQ.push_back('{ack: 1'b0, err: 1'b0, dat: lastRead, lat: 0});
        @(posedge clk); #1;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 32'h0000_5000; bus.wb_sel = 4'b1111; bus.wb_dat_w = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk); #1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.wb_ack === 1'b1) sawAck = 1'b1;
            if (bus.wb_err === 1'b1) sawErr = 1'b1;
        end
        cfgWait = 0;
        e = expQ.pop_front();
        checks++;
        if ({sawAck, sawErr} !== {e.ack, e.err}) begin
            errors++; $display("[TB] FAIL abort_silent: got ack=%b err=%b expected %b/%b", sawAck, sawErr, e.ack, e.err);
        end
        checks++;
        if (dataDone - done0 != 1 || capWdata !== 32'hCAFE_F00D || bus.HTRANS !== 2'b00) begin
            errors++; $display("[TB] FAIL abort_completes: got done=%0d wdata=%h htrans=%b expected 1/cafef00d/00",
                               dataDone - done0, capWdata, bus.HTRANS);
        end
        cfgRdata = 32'h600D_600D; lastRead = 32'h600D_600D;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: 32'h600D_600D, lat: 3});
        wbTransfer(1'b0, 32'h0000_5004, 4'b1111, 32'h0, a, er, d, cyc, lg);
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || d !== e.dat) begin
            errors++; $display("[TB] FAIL after_abort: got ack=%b err=%b lat=%0d dat=%h expected %b/%b/%0d/%h",
                               a, er, cyc, d, e.ack, e.err, e.lat, e.dat);
        end
    endtask

    task automatic test_reset_in_addr();
        logic a, er, lg; logic [31:0] d; int cyc; exp_t e;
        cfgAddrWait = 3;
        @(posedge clk); #1;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = 32'h0000_4008; bus.wb_sel = 4'b1111; bus.wb_dat_w = 32'h55AA_55AA;
        @(posedge clk); #1;
        checks++;
        if (bus.HTRANS !== 2'b10 || bus.HWRITE !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_addr_setup: got htrans=%b wr=%b expected 10/1", bus.HTRANS, bus.HWRITE);
        end
        rst = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lastRead = 32'h0;
        checks++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA} !== {2'b00, 32'h0, 1'b0, 3'b010, 32'h0}) begin
            errors++; $display("[TB] FAIL rst_addr_ahb: got htrans=%b addr=%h wr=%b size=%b wdata=%h expected 00/0/0/010/0",
                               bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE, bus.HWDATA);
        end
        checks++;
        if ({bus.wb_dat_r, bus.wb_ack, bus.wb_err} !== {32'h0, 1'b0, 1'b0}) begin
            errors++; $display("[TB] FAIL rst_addr_wb: got dat=%h ack=%b err=%b expected 0/0/0",
                               bus.wb_dat_r, bus.wb_ack, bus.wb_err);
        end
        cfgAddrWait = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cfgRdata = 32'h0BAD_F00D; lastRead = 32'h0BAD_F00D;
        expQ.push_back('{ack: 1'b1, err: 1'b0, dat: 32'h0BAD_F00D, lat: 3});
        wbTransfer(1'b0, 32'h0000_4000, 4'b1111, 32'h0, a, er, d, cyc, lg);
        e = expQ.pop_front();
        checks++;
        if ({a, er} !== {e.ack, e.err} || cyc != e.lat || d !== e.dat || ahbViol != 0) begin
            errors++; $display("[TB] FAIL after_reset: got ack=%b err=%b lat=%0d dat=%h viol=%0d expected %b/%b/%0d/%h/0",
                               a, er, cyc, d, ahbViol, e.ack, e.err, e.lat, e.dat);
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_read_wait();
        test_error();
        test_invalid_sel();
        test_sel_decode();
        test_addr_wait();
        test_abort();
        test_reset_in_addr();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wishbone_to_ahb.md
Name: wishbone_to_ahb

Overview:
- Bridge with a Wishbone classic slave on one side and an AHB-Lite master on the other. Each Wishbone cycle becomes one single AHB transfer.
- Lets Wishbone-side masters (Controller, test harness) reach AHB-Lite slave memories and peripherals on the core bus.
- One outstanding transfer at a time; no pipelining.

Parameters:
- HPROT_VALUE, 4'b0011, constant driven on HPROT (data access, privileged).
- ADDR_WIDTH, 32, width of wb_adr and HADDR.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  sole clock for both sides
- rst  in  1  synchronous, active-high reset
- wb_cyc  in  1  Wishbone cycle valid
- wb_stb  in  1  Wishbone strobe
- wb_we  in  1  1 = write
- wb_adr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- wb_sel  in  4  byte-lane select
- wb_dat_w  in  32  write data, lanes already positioned
- wb_dat_r  out  32  read data
- wb_ack  out  1  normal termination
- wb_err  out  1  error termination
- HADDR  out  ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE=00 or NONSEQ=10
- HWRITE  out  1  transfer direction
- HSIZE  out  3  000 byte, 001 half, 010 word
- HBURST  out  3  constant 000 (SINGLE)
- HPROT  out  4  constant HPROT_VALUE
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  write data
- HRDATA  in  32  read data
- HREADY  in  1  AHB ready
- HRESP  in  1  1 = ERROR

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE.
- Reset values: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0, wb_dat_r=0, wb_ack=0, wb_err=0, abort flag=0.
- **IDLE:**
  - On wb_cyc&wb_stb, register HWRITE=wb_we and HWDATA=wb_dat_w; compute HADDR/HSIZE from wb_sel.
  - If wb_sel is valid, go to ADDR.
  - If wb_sel is invalid, go to DONE with err pending. No AHB transfer is issued.
- wb_sel decode:
  - 0001/0010/0100/1000: HSIZE=000, HADDR[1:0]=00/01/10/11.
  - 0011: HSIZE=001, HADDR[1:0]=00.
  - 1100: HSIZE=001, HADDR[1:0]=10.
  - 1111: HSIZE=010, HADDR[1:0]=00.
  - All other values (including 0000) are invalid.
  - HADDR[ADDR_WIDTH-1:2]=wb_adr[ADDR_WIDTH-1:2].
- **ADDR:**
  - HTRANS=NONSEQ; address and control outputs are stable.
  - Stay in ADDR while HREADY=0. When HREADY=1, set HTRANS=IDLE and go to DATA.
- **DATA:**
  - HWDATA held; HTRANS=IDLE.
  - Wait for HREADY=1. On that edge: capture HRDATA into wb_dat_r (reads only; writes leave it unchanged), record HRESP, go to DONE.
  - HRESP=1 with HREADY=0 (first cycle of the two-cycle ERROR response) is ignored; the result is taken on the HREADY=1 cycle.
- **DONE:**
  - Asserts exactly one of wb_ack (HRESP=0) or wb_err (HRESP=1 or invalid sel) for one cycle, then returns to IDLE.
  - A new request may be accepted in the cycle after DONE.
- Latency, zero-wait slave: request sampled at edge T, ack visible T+3. Each HREADY wait cycle adds 1.
- AHB master rules:
  - HTRANS is never NONSEQ outside ADDR.
  - Address/control never change while in ADDR with HREADY=0.
  - HMASTLOCK=0 and HBURST=000 always.
- wb_cyc dropped mid-transfer (ADDR or DATA):
  - The AHB transfer still completes; it cannot be aborted.
  - The abort flag is set, and DONE asserts neither ack nor err.
  - The abort flag clears on entering IDLE.
- wb_dat_r holds its last read value until the next read completes.
- rst asserted in any state: next edge goes to IDLE with reset values and any in-flight AHB transfer is abandoned. System reset covers the slaves too.
- wb_ack and wb_err are never asserted together. Neither is asserted without a preceding accepted request.

Test Plan:
- Word read, HREADY=1, HRDATA=32'hDEADBEEF, wb_adr=32'h0000_1004, sel=1111
  -> HADDR=32'h1004, HSIZE=010, HTRANS=NONSEQ for exactly 1 cycle; wb_ack at T+3; wb_dat_r=DEADBEEF.
- Byte write, wb_adr=32'h2000, sel=0100, dat_w=32'h00AB0000
  -> HADDR=32'h2002, HSIZE=000, HWRITE=1; HWDATA=00AB0000 in data phase; wb_ack one cycle.
- Half read, sel=1100, slave inserts 3 HREADY=0 cycles in data phase
  -> HADDR[1:0]=10, HSIZE=001; ack at T+6; wb_dat_r = HRDATA from the HREADY=1 cycle.
- Slave returns ERROR: HRESP=1/HREADY=0 then HRESP=1/HREADY=1
  -> wb_err one cycle, wb_ack stays 0.
- Invalid sel=0101
  -> wb_err at T+1, HTRANS stays 00 throughout.
- Two more cases, run as separate sequences:
  - wb_cyc dropped during DATA -> AHB transfer completes, no ack/err.
  - rst asserted in ADDR -> next cycle HTRANS=00, state IDLE, all outputs at reset values.
